// File: rtl/md_stream_pkg.sv
// md_stream_pkg: shared types for the MD particle streamer.
//   st_e    - sequencer FSM states
//   IN_W_D  - default particle record width written to the core
//   OUT_W_D - default record width returned by the core
//   cnt_w() - width for a down-counter that must hold 0..n (never 0 bits)
package md_stream_pkg;

  localparam int IN_W_D  = 210;
  localparam int OUT_W_D = 192;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_RD,
    S_LOAD_WR,
    S_LOAD_GAP,
    S_RUN,
    S_DRAIN_REQ,
    S_DRAIN_WAIT,
    S_DRAIN_OUT,
    S_NEXT,
    S_DONE
  } st_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/md_stream_cnt.sv
// md_stream_cnt: loadable down-counter with zero flag.
//   ap_clk/ap_rst_n - clock, async active-low reset
//   load/load_val   - load takes priority over decrement
//   en              - decrement; saturates at zero
//   zero            - count is zero
module md_stream_cnt #(
  parameter int W = 8
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)          cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (en && !zero)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_particle_streamer.sv
// md_particle_streamer: host-side load/run/drain sequencer for the MD core.
// Loads NUM_P records from a source RAM into the core (elem_write), waits
// RUN_CYCLES, drains NUM_P records via read_ctrl/elem_read into a
// valid/ready stream, and repeats run+drain for num_steps timesteps.
// Ports:
//   ap_clk, ap_rst_n               clock, async active-low reset
//   start, num_steps, busy, done   control (num_steps 0 runs one step)
//   src_addr, src_rd_en, src_data  source RAM, 1-cycle read latency
//   d_in, elem_write, step         core load side / timestep index
//   read_ctrl, elem_read, d_out    core drain handshake
//   out_valid, out_data, out_ready output stream
//   err                            sticky drain timeout flag
// Optional: define STREAMER_TIMEOUT_EN to bound DRAIN_WAIT by TIMEOUT
// cycles; a timed-out particle is emitted as an all-zero record.
module md_particle_streamer
  import md_stream_pkg::*;
#(
  parameter int IN_W       = IN_W_D,
  parameter int OUT_W      = OUT_W_D,
  parameter int NUM_P      = 300,
  parameter int AW         = (NUM_P > 1) ? $clog2(NUM_P) : 1,
  parameter int GAP        = 64,
  parameter int RUN_CYCLES = 10000,
  parameter int TIMEOUT    = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic [31:0]      num_steps,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    src_addr,
  output logic             src_rd_en,
  input  logic [IN_W-1:0]  src_data,
  output logic [IN_W-1:0]  d_in,
  output logic             elem_write,
  output logic [31:0]      step,
  output logic             read_ctrl,
  input  logic             elem_read,
  input  logic [OUT_W-1:0] d_out,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             err
);

  localparam int GW = cnt_w(GAP);
  localparam int RW = cnt_w(RUN_CYCLES);
  // Counters load N-1 and the state exits on the zero flag, so the state
  // lasts exactly N cycles (minimum one).
  localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;
  localparam int RUN_LD = (RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0;
  localparam bit GAP_NONE = (GAP == 0);
  localparam logic [AW-1:0] LAST = AW'(NUM_P - 1);

  st_e              state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [31:0]      step_q, steps_q;
  logic [IN_W-1:0]  d_in_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             gap_zero, run_zero, to_hit;
  logic             idx_last;

  assign idx_last = (idx_q == LAST);

  md_stream_cnt #(.W(GW)) u_gap (
    .ap_clk, .ap_rst_n,
    .load     (state_q == S_LOAD_WR),
    .en       (state_q == S_LOAD_GAP),
    .load_val (GW'(GAP_LD)),
    .zero     (gap_zero)
  );

  md_stream_cnt #(.W(RW)) u_run (
    .ap_clk, .ap_rst_n,
    .load     (state_d == S_RUN && state_q != S_RUN),
    .en       (state_q == S_RUN),
    .load_val (RW'(RUN_LD)),
    .zero     (run_zero)
  );

`ifdef STREAMER_TIMEOUT_EN
  localparam int TW    = cnt_w(TIMEOUT);
  localparam int TO_LD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  logic to_zero;
  logic err_q;

  md_stream_cnt #(.W(TW)) u_to (
    .ap_clk, .ap_rst_n,
    .load     (state_q == S_DRAIN_REQ),
    .en       (state_q == S_DRAIN_WAIT),
    .load_val (TW'(TO_LD)),
    .zero     (to_zero)
  );

  // A real response in the expiry cycle still wins over the timeout.
  assign to_hit = (state_q == S_DRAIN_WAIT) && !elem_read && to_zero;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   err_q <= 1'b0;
    else if (to_hit) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start) state_d = S_LOAD_RD;
      S_LOAD_RD:    state_d = S_LOAD_WR;
      S_LOAD_WR:    if (idx_last)      state_d = S_RUN;
                    else if (GAP_NONE) state_d = S_LOAD_RD;
                    else               state_d = S_LOAD_GAP;
      S_LOAD_GAP:   if (gap_zero) state_d = S_LOAD_RD;
      S_RUN:        if (run_zero) state_d = S_DRAIN_REQ;
      S_DRAIN_REQ:  state_d = S_DRAIN_WAIT;
      S_DRAIN_WAIT: if (elem_read || to_hit) state_d = S_DRAIN_OUT;
      S_DRAIN_OUT:  if (out_valid_q && out_ready)
                      state_d = idx_last ? S_NEXT : S_DRAIN_REQ;
      S_NEXT:       state_d = (step_q + 32'd1 == steps_q) ? S_DONE : S_RUN;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx_q       <= '0;
      step_q      <= '0;
      steps_q     <= '0;
      d_in_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          steps_q <= (num_steps == 32'd0) ? 32'd1 : num_steps;
          step_q  <= '0;
          idx_q   <= '0;
        end
        S_LOAD_WR: begin
          d_in_q <= src_data;
          if (!idx_last) idx_q <= idx_q + 1'b1;
        end
        S_RUN: if (run_zero) idx_q <= '0;
        S_DRAIN_WAIT: begin
          if (elem_read) begin
            out_data_q  <= d_out;
            out_valid_q <= 1'b1;
          end else if (to_hit) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b1;
          end
        end
        S_DRAIN_OUT: if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
          if (!idx_last) idx_q <= idx_q + 1'b1;
        end
        S_NEXT: if (step_q + 32'd1 != steps_q) step_q <= step_q + 32'd1;
        default: ;
      endcase
    end
  end

  // Outputs. d_in passes RAM data straight through in LOAD_WR (RAM data
  // is valid that cycle and held), then holds the captured copy.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    src_rd_en  = (state_q == S_LOAD_RD);
    src_addr   = (state_q == S_LOAD_RD) ? idx_q : '0;
    elem_write = (state_q == S_LOAD_WR);
    d_in       = (state_q == S_LOAD_WR) ? src_data : d_in_q;
    read_ctrl  = (state_q == S_DRAIN_REQ);
    step       = step_q;
    out_valid  = out_valid_q;
    out_data   = out_data_q;
  end

endmodule

// File: tb/tb_md_particle_streamer.sv
module tb_md_particle_streamer;

  localparam int IN_W  = 210;
  localparam int OUT_W = 192;
  localparam int NUM_P = 4;
  localparam int AW    = 2;
  localparam int GAP   = 2;
  localparam int RUN_C = 8;
  localparam int TO    = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      num_steps = '0;
  logic             busy, done, src_rd_en, elem_write, read_ctrl, out_valid, err;
  logic [AW-1:0]    src_addr;
  logic [IN_W-1:0]  src_data = '0;
  logic [IN_W-1:0]  d_in;
  logic [31:0]      step;
  logic             elem_read = 1'b0;
  logic [OUT_W-1:0] d_out = '0;
  logic [OUT_W-1:0] out_data;
  logic             out_ready = 1'b1;

  always #5 ap_clk = ~ap_clk;

  md_particle_streamer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_P(NUM_P), .AW(AW),
    .GAP(GAP), .RUN_CYCLES(RUN_C), .TIMEOUT(TO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .num_steps(num_steps),
    .busy(busy), .done(done), .src_addr(src_addr), .src_rd_en(src_rd_en),
    .src_data(src_data), .d_in(d_in), .elem_write(elem_write), .step(step),
    .read_ctrl(read_ctrl), .elem_read(elem_read), .d_out(d_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source RAM, one-cycle read latency
  logic [IN_W-1:0] mem [NUM_P];
  always @(posedge ap_clk) if (src_rd_en) src_data <= mem[src_addr];

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Scoreboard
  logic [IN_W-1:0]  exp_wr[$];
  logic [OUT_W-1:0] exp_out[$];
  int done_cnt = 0;
  int nwr = 0;
  int start_cyc = 0;
  int last_wr = 0;
  bit hold_pend = 0;
  logic [OUT_W-1:0] hold_data;

  initial forever begin
    @(negedge ap_clk);
    if (!ap_rst_n) begin
      hold_pend = 0;
    end else begin
      if (start && !busy) begin start_cyc = cyc; nwr = 0; end
      if (elem_write) begin
        int lat, elat;
        if (exp_wr.size() == 0) chk(1'b0, "wr_extra", 256'(d_in), 256'(0));
        else begin
          logic [IN_W-1:0] e;
          e = exp_wr.pop_front();
          chk(d_in == e, "d_in", 256'(d_in), 256'(e));
        end
        lat  = (nwr == 0) ? cyc - start_cyc : cyc - last_wr;
        elat = (nwr == 0) ? 2 : 2 + GAP;
        chk(lat == elat, "wr_timing", 256'(lat), 256'(elat));
        last_wr = cyc;
        nwr++;
      end
      if (read_ctrl) chk(!out_valid, "rdctrl_while_valid", 256'(out_valid), 256'(0));
      if (hold_pend)
        chk(out_valid && out_data == hold_data, "out_hold", 256'(out_data), 256'(hold_data));
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk(1'b0, "out_extra", 256'(out_data), 256'(0));
        else begin
          logic [OUT_W-1:0] e;
          e = exp_out.pop_front();
          chk(out_data == e, "out_data", 256'(out_data), 256'(e));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Core model: stores loaded records, answers each read_ctrl in order
  // after 0..3 cycles with {step at request, low 160 bits of the record}.
  logic [IN_W-1:0] core_mem [NUM_P];
  int  drop_idx = -1;
  bit  spur_en = 1;
  initial begin
    int wp, rp, lat, req_i;
    bit pend, rc, wr;
    logic [IN_W-1:0] din;
    logic [31:0] st, req_st;
    wp = 0; rp = 0; pend = 0; lat = 0; req_i = 0; req_st = '0;
    forever begin
      @(negedge ap_clk);
      rc = read_ctrl; wr = elem_write; din = d_in; st = step;
      @(posedge ap_clk); #1;
      elem_read = 1'b0;
      if (!ap_rst_n) begin
        wp = 0; rp = 0; pend = 0;
      end else begin
        if (wr) begin core_mem[wp] = din; wp = (wp + 1) % NUM_P; end
        if (rc) begin
          pend = 1; lat = $urandom_range(0, 3); req_st = st; req_i = rp;
          rp = (rp + 1) % NUM_P;
          if (req_i == drop_idx) begin pend = 0; drop_idx = -1; end
        end
        if (pend) begin
          if (lat == 0) begin
            elem_read = 1'b1;
            d_out = {req_st, core_mem[req_i][159:0]};
            pend = 0;
          end else lat--;
        end else if (!rc && spur_en && $urandom_range(0, 7) == 0) begin
          // stray response outside a request: must be ignored
          elem_read = 1'b1;
          d_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  int stall = 0;
  initial forever begin
    @(posedge ap_clk); #1;
    if (stall > 0) begin out_ready = 1'b0; stall--; end
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic fill_mem(input bit fixed);
    logic [223:0] r;
    for (int i = 0; i < NUM_P; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem[i] = fixed ? IN_W'(8'hA0 + i) : r[IN_W-1:0];
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({busy, done, src_rd_en, elem_write, read_ctrl, out_valid, err} == 7'd0,
        {name, "_ctrl"}, 256'({busy, done, src_rd_en, elem_write, read_ctrl, out_valid, err}), 256'(0));
    chk(src_addr == '0 && step == '0, {name, "_addr_step"}, 256'({src_addr, step}), 256'(0));
    chk(d_in == '0, {name, "_d_in"}, 256'(d_in), 256'(0));
    chk(out_data == '0, {name, "_out_data"}, 256'(out_data), 256'(0));
  endtask

  task automatic run_test(input int ns, input bit fixed, input bit do_stall,
                          input bit extra_start, input int drop, input bit exp_err);
    int eff, d0, n;
    eff = (ns == 0) ? 1 : ns;
    fill_mem(fixed);
    for (int i = 0; i < NUM_P; i++) exp_wr.push_back(mem[i]);
    for (int s = 0; s < eff; s++)
      for (int i = 0; i < NUM_P; i++)
        exp_out.push_back((s == 0 && i == drop) ? OUT_W'(0) : {32'(s), mem[i][159:0]});
    drop_idx = drop;
    spur_en = (drop < 0);
    d0 = done_cnt;
    @(posedge ap_clk); #1; num_steps = 32'(ns); start = 1'b1;
    @(posedge ap_clk); #1; start = 1'b0;
    @(negedge ap_clk);
    chk(busy, "busy_after_start", 256'(busy), 256'(1));
    if (extra_start) begin
      repeat (3) @(posedge ap_clk);
      #1; start = 1'b1; num_steps = 32'd7;
      @(posedge ap_clk); #1; start = 1'b0;
    end
    if (do_stall) begin
      n = 0;
      while (exp_out.size() > eff * NUM_P - 2 && n < 5000) begin @(posedge ap_clk); n++; end
      while (!out_valid && n < 5000) begin @(posedge ap_clk); n++; end
      stall = 5;
    end
    n = 0;
    while (done_cnt == d0 && n < 20000) begin @(posedge ap_clk); n++; end
    chk(done_cnt != d0, "done_seen", 256'(done_cnt), 256'(d0 + 1));
    repeat (3) @(negedge ap_clk);
    chk(done_cnt == d0 + 1, "done_once", 256'(done_cnt), 256'(d0 + 1));
    chk(!busy, "busy_after_done", 256'(busy), 256'(0));
    chk(exp_wr.size() == 0, "wr_count_left", 256'(exp_wr.size()), 256'(0));
    chk(exp_out.size() == 0, "out_count_left", 256'(exp_out.size()), 256'(0));
    chk(err == exp_err, "err", 256'(err), 256'(exp_err));
    exp_wr.delete();
    exp_out.delete();
  endtask

  initial begin
    int n;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_idle_outputs("reset");
    @(posedge ap_clk); #1; ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);

    run_test(1, 1'b1, 1'b0, 1'b1, -1, 1'b0);  // 0xA0..0xA3, ignored 2nd start
    run_test(0, 1'b0, 1'b0, 1'b0, -1, 1'b0);  // 0 steps behaves as 1
    run_test(3, 1'b0, 1'b1, 1'b0, -1, 1'b0);  // 3 steps, 5-cycle stall

    // Async reset in the gap after the third write
    fill_mem(1'b0);
    for (int i = 0; i < NUM_P; i++) exp_wr.push_back(mem[i]);
    @(posedge ap_clk); #1; num_steps = 32'd1; start = 1'b1;
    @(posedge ap_clk); #1; start = 1'b0;
    n = 0;
    while (nwr < 3 && n < 200) begin @(posedge ap_clk); n++; end
    chk(nwr == 3, "reach_gap", 256'(nwr), 256'(3));
    @(posedge ap_clk); #2; ap_rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    exp_wr.delete();
    exp_out.delete();
    repeat (2) @(posedge ap_clk);
    #1; ap_rst_n = 1'b1;
    run_test(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);  // reload from idx 0 after abort

`ifdef STREAMER_TIMEOUT_EN
    run_test(1, 1'b0, 1'b0, 1'b0, 1, 1'b1);   // particle 1 never answered
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
